reg_writeback_queue: RTL
========================

Name: reg_writeback_queue

Overview:
- Write-side master for the 8x16 register file. Drives its write port: `sig_regWrite`, `wr_addr`, `wr_data`.
- Collects completed results from the ALU path and the memory-load path through valid/ready handshakes.
- Buffers results in a shared FIFO and retires at most one register write per clock, in acceptance order.
- Exports a pending-write mask so the decode/hazard logic can stall readers of registers with queued writes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- DATA_W, 16, register data width
- ADDR_W, 3, register address width (2^ADDR_W registers)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- alu_valid  in  1  ALU result available
- alu_ready  out  1  ALU result accepted this cycle when alu_valid=1
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load result available
- mem_ready  out  1  load result accepted this cycle when mem_valid=1
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- drain_en  in  1  1 = a FIFO head may retire this cycle; 0 = hold
- flush  in  1  synchronous discard of all queued, not-yet-issued writes
- sig_regWrite  out  1  register-file write enable, registered
- wr_addr  out  ADDR_W  register-file write address, registered
- wr_data  out  DATA_W  register-file write data, registered
- pending_mask  out  2^ADDR_W  bit i = 1 if any FIFO entry or the current output write targets register i
- count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst=1):
  - FIFO pointers and count = 0.
  - sig_regWrite = 0, wr_addr = 0, wr_data = 0.
  - pending_mask = 0.
  - alu_ready and mem_ready = 0 while rst is high.
- Storage: circular FIFO of {addr, data}, DEPTH entries. Read/write pointers wrap modulo DEPTH. full = (count == DEPTH); empty = (count == 0).
- Acceptance (at most one push per cycle):
  - mem_ready = !full && !flush.
  - alu_ready = !full && !flush && !mem_valid. Load has priority.
  - Push occurs on the edge when (mem_valid && mem_ready) or (alu_valid && alu_ready).
  - Ready depends only on registered count. A simultaneous pop does not free space for the same-cycle push.
  - Producers hold valid, addr and data stable until ready.
- Retire:
  - A pop occurs on the edge when !empty && drain_en && !flush.
  - On a pop, next cycle sig_regWrite=1 with wr_addr/wr_data = head entry.
  - Otherwise next cycle sig_regWrite=0; wr_addr/wr_data hold their last values.
  - sig_regWrite is high for exactly one cycle per retired entry.
  - Back-to-back retires give consecutive high cycles.
- Latency: a result pushed at edge N into an empty FIFO with drain_en=1 gives sig_regWrite=1 after edge N+1. The register file captures it at edge N+2.
- Simultaneous push and pop: count is unchanged. Both pointers advance.
- Ordering:
  - Strict FIFO order.
  - Two queued writes to the same register both retire, the older first. No coalescing.
  - Writes to register 0 are retired like any other.
- Flush:
  - Next edge: count=0, read pointer = write pointer, sig_regWrite=0.
  - No push and no pop in the flush cycle.
  - A write already on the outputs during the flush cycle completes, because the register file samples it at that same edge.
- pending_mask:
  - Combinational OR of the one-hot decoded addresses of all valid FIFO entries, plus wr_addr when sig_regWrite=1.
  - Clears for register i only once no FIFO entry or output write targets i.
- Reset mid-operation: all queued writes are lost. Outputs go to reset values immediately, without waiting for a clock edge.

Test Plan:
- Basic write: reset; alu_valid with addr 3, data 0x0045, drain_en=1 → alu_ready=1; next cycle count=1, pending_mask=0x08; next cycle sig_regWrite=1, wr_addr=3, wr_data=0x0045, for one cycle; then pending_mask=0x00.
- Priority: alu (r1, 0x000E) and mem (r2, 0x0004) valid together → mem accepted first with alu_ready=0; alu accepted the following cycle; writes retire in order r2 then r1, on consecutive cycles.
- Full/backpressure: drain_en=0; push 4 results to r4..r7 → count=4, alu_ready=mem_ready=0, pending_mask=0xF0; a 5th valid is held. Raise drain_en → 4 writes in order r4..r7; the 5th is accepted once count<4.
- Same-register ordering: push r5=0x1111 then r5=0x2222 → two sig_regWrite pulses to r5, 0x1111 then 0x2222; pending_mask bit 5 clears only after the second.
- Flush: drain_en=0; queue 3 entries; pulse flush → next cycle count=0, pending_mask=0, ready deasserted during the flush cycle, no sig_regWrite afterwards.
- Async reset: queue 2 entries, with sig_regWrite high; assert rst between clock edges → sig_regWrite, wr_addr, wr_data, count and pending_mask go to 0 immediately; after release, no stale writes appear.

Source files
------------

// File: rtl/reg_writeback_queue.sv
// Register-file write-side master: accepts ALU and load results through
// valid/ready, buffers them in a shared FIFO and retires one write per clock
// in acceptance order. Also publishes a mask of registers with writes in flight.
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [ADDR_W-1:0]         alu_addr,
  input  logic [DATA_W-1:0]         alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_data,
  input  logic                      drain_en,
  input  logic                      flush,
  output logic                      sig_regWrite,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [(1<<ADDR_W)-1:0]    pending_mask,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              sig_q, sig_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              full, empty, push, pop;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;
  logic [PTR_W-1:0]  idx;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Readiness looks only at registered occupancy; a same-cycle pop never frees
  // room for a same-cycle push. Loads win over ALU results.
  assign mem_ready = !rst && !full && !flush;
  assign alu_ready = !rst && !full && !flush && !mem_valid;

  assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign push_addr = mem_valid ? mem_addr : alu_addr;
  assign push_data = mem_valid ? mem_data : alu_data;
  assign pop       = !empty && drain_en && !flush;

  // Next-state for pointers, occupancy and the registered write port
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    sig_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (flush) begin
      rptr_d  = wptr_q;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop) begin
        rptr_d    = rptr_q + 1'b1;
        sig_d     = 1'b1;
        wr_addr_d = fifo_addr_q[rptr_q];
        wr_data_d = fifo_data_q[rptr_q];
      end
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      sig_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      sig_q     <= sig_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Entry storage; validity is tracked by the pointers so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= push_addr;
      fifo_data_q[wptr_q] <= push_data;
    end
  end

  // Registers with a queued or in-flight write, for reader stall logic
  always_comb begin
    pending_mask = '0;
    idx          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) pending_mask[fifo_addr_q[idx]] = 1'b1;
    end
    if (sig_q) pending_mask[wr_addr_q] = 1'b1;
  end

  assign sig_regWrite = sig_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign count        = count_q;

endmodule
